age_ordered_req_buf: RTL and testbench

Out-of-order request buffer that sits on the producer side of the on-chip cache age-ordered selection path. Requests enqueue into free slots and may wait on a wake tag (for example, an outstanding refill). Each slot's relative age is tracked in an internal age matrix. The oldest ready entry is issued downstream over a valid/ready handshake. The block owns allocation, age bookkeeping and wakeup, which are the write side of the age-select protocol.

---
 rtl/age_ordered_req_buf.sv | 123 ++++++++++++
 tb/tb_age_ordered_req_buf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/age_ordered_req_buf.sv
// Out-of-order request buffer: allocates free slots, tracks relative age in a
// matrix, wakes waiters by tag and issues the oldest ready entry downstream.
module age_ordered_req_buf #(
  parameter int EntryCount = 4,
  parameter int DataWidth  = 32,
  parameter int TagWidth   = 4,
  parameter int IdxWidth   = $clog2(EntryCount)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_vld_i,
  output logic                 enq_rdy_o,
  input  logic [DataWidth-1:0] enq_data_i,
  input  logic                 enq_wait_i,
  input  logic [TagWidth-1:0]  enq_tag_i,
  input  logic                 wake_vld_i,
  input  logic [TagWidth-1:0]  wake_tag_i,
  output logic                 deq_vld_o,
  input  logic                 deq_rdy_i,
  output logic [DataWidth-1:0] deq_data_o,
  output logic [IdxWidth-1:0]  deq_idx_o,
  output logic [IdxWidth:0]    occupancy_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [EntryCount-1:0] r_vld;
  logic [EntryCount-1:0] r_rdy;
  logic [TagWidth-1:0]   r_tag   [EntryCount];
  logic [DataWidth-1:0]  r_data  [EntryCount];
  logic [EntryCount-1:0] r_older [EntryCount];
  logic                  r_lock_vld;
  logic [IdxWidth-1:0]   r_lock_idx;
  logic [IdxWidth:0]     r_occ;

  logic [EntryCount-1:0] w_cand;
  logic [IdxWidth-1:0]   w_old_idx;
  logic [IdxWidth-1:0]   w_free_idx;
  logic [IdxWidth-1:0]   w_pres_idx;
  logic                  w_full;
  logic                  w_enq_fire;
  logic                  w_deq_fire;
  logic                  w_enq_rdy_st;
  logic [IdxWidth:0]     w_occ_nxt;

  assign w_cand = r_vld & r_rdy;

  // A candidate is oldest when its row marks it older than every other candidate.
  always_comb begin
    logic w_ok;
    w_old_idx = '0;
    for (int r = 0; r < EntryCount; r++) begin
      w_ok = w_cand[r];
      for (int c = 0; c < EntryCount; c++) begin
        if (c != r && w_cand[c] && !r_older[r][c]) w_ok = 1'b0;
      end
      if (w_ok) w_old_idx = IdxWidth'(r);
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = EntryCount - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_free_idx = IdxWidth'(i);
    end
  end

  assign w_full       = (r_occ == (IdxWidth+1)'(EntryCount));
  assign w_pres_idx   = r_lock_vld ? r_lock_idx : w_old_idx;
  assign w_enq_fire   = enq_vld_i & ~w_full;
  assign w_deq_fire   = deq_vld_o & deq_rdy_i;
  assign w_enq_rdy_st = ~enq_wait_i | (wake_vld_i & (wake_tag_i == enq_tag_i));
  assign w_occ_nxt    = r_occ + (IdxWidth+1)'(w_enq_fire) - (IdxWidth+1)'(w_deq_fire);

  assign enq_rdy_o   = ~w_full;
  assign deq_vld_o   = r_lock_vld | (|w_cand);
  assign deq_idx_o   = w_pres_idx;
  assign deq_data_o  = r_data[w_pres_idx];
  assign occupancy_o = r_occ;
  assign full_o      = w_full;
  assign empty_o     = (r_occ == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_rdy      <= '0;
      r_lock_vld <= 1'b0;
      r_lock_idx <= '0;
      r_occ      <= '0;
      for (int i = 0; i < EntryCount; i++) r_older[i] <= '0;
    end else begin
      for (int i = 0; i < EntryCount; i++) begin
        if (wake_vld_i && r_vld[i] && !r_rdy[i] && r_tag[i] == wake_tag_i) r_rdy[i] <= 1'b1;
      end
      // A stalled presentation is pinned so a later-waking older entry cannot swap it out.
      if (w_deq_fire) begin
        r_vld[w_pres_idx] <= 1'b0;
        r_rdy[w_pres_idx] <= 1'b0;
        r_lock_vld        <= 1'b0;
      end else if (deq_vld_o) begin
        r_lock_vld <= 1'b1;
        r_lock_idx <= w_pres_idx;
      end
      if (w_enq_fire) begin
        r_vld[w_free_idx]   <= 1'b1;
        r_rdy[w_free_idx]   <= w_enq_rdy_st;
        r_older[w_free_idx] <= '0;
        for (int c = 0; c < EntryCount; c++) begin
          if (c != int'(w_free_idx)) r_older[c][w_free_idx] <= r_vld[c];
        end
      end
      r_occ <= w_occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_data[w_free_idx] <= enq_data_i;
      r_tag[w_free_idx]  <= enq_tag_i;
    end
  end

endmodule

// File: tb/tb_age_ordered_req_buf.sv
// Bench for age_ordered_req_buf: directed scenarios plus random traffic, checked
// against a timestamp-based reference model of the buffer.
module tb_age_ordered_req_buf;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        enq_vld;
  logic        enq_rdy;
  logic [31:0] enq_data;
  logic        enq_wait;
  logic [3:0]  enq_tag;
  logic        wake_vld;
  logic [3:0]  wake_tag;
  logic        deq_vld;
  logic        deq_rdy;
  logic [31:0] deq_data;
  logic [1:0]  deq_idx;
  logic [2:0]  occ;
  logic        full;
  logic        empty;

  age_ordered_req_buf #(.EntryCount(N), .DataWidth(32), .TagWidth(4)) dut (
    .clk(clk), .rst(rst),
    .enq_vld_i(enq_vld), .enq_rdy_o(enq_rdy), .enq_data_i(enq_data),
    .enq_wait_i(enq_wait), .enq_tag_i(enq_tag),
    .wake_vld_i(wake_vld), .wake_tag_i(wake_tag),
    .deq_vld_o(deq_vld), .deq_rdy_i(deq_rdy), .deq_data_o(deq_data),
    .deq_idx_o(deq_idx), .occupancy_o(occ), .full_o(full), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each slot carries an allocation timestamp; oldest = smallest.
  bit          m_vld  [N];
  bit          m_rdy  [N];
  int          m_tag  [N];
  logic [31:0] m_data [N];
  int          m_seq  [N];
  int          seq_ctr;
  bit          m_lock;
  int          m_lock_idx;
  logic [31:0] deq_log[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic int m_pres();
    int best;
    if (m_lock) return m_lock_idx;
    best = -1;
    for (int i = 0; i < N; i++)
      if (m_vld[i] && m_rdy[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 0;
      m_rdy[i] = 0;
    end
    m_lock = 0;
  endfunction

  task automatic cycle();
    int cnt, pres, free;
    bit dv, ef, df;
    #2;
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_vld[i]) cnt++;
    pres = m_pres();
    dv = (pres >= 0);
    chk("enq_rdy", enq_rdy, cnt < N);
    chk("deq_vld", deq_vld, dv);
    chk("occupancy", occ, cnt);
    chk("full", full, cnt == N);
    chk("empty", empty, cnt == 0);
    if (dv) begin
      chk("deq_idx", deq_idx, pres);
      chk("deq_data", deq_data, m_data[pres]);
    end
    if (rst) begin
      m_clear();
    end else begin
      ef = enq_vld && cnt < N;
      df = dv && deq_rdy;
      free = -1;
      for (int i = 0; i < N; i++) if (!m_vld[i] && free < 0) free = i;
      if (df) deq_log.push_back(m_data[pres]);
      for (int i = 0; i < N; i++)
        if (wake_vld && m_vld[i] && !m_rdy[i] && m_tag[i] == int'(wake_tag)) m_rdy[i] = 1;
      if (df) begin
        m_vld[pres] = 0;
        m_rdy[pres] = 0;
        m_lock = 0;
      end else if (dv) begin
        m_lock = 1;
        m_lock_idx = pres;
      end
      if (ef) begin
        m_vld[free]  = 1;
        m_rdy[free]  = !enq_wait || (wake_vld && wake_tag == enq_tag);
        m_tag[free]  = int'(enq_tag);
        m_data[free] = enq_data;
        m_seq[free]  = seq_ctr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ev, input bit ew, input int et, input logic [31:0] ed,
                       input bit wv, input int wt, input bit dr);
    enq_vld  = ev;
    enq_wait = ew;
    enq_tag  = 4'(et);
    enq_data = ed;
    wake_vld = wv;
    wake_tag = 4'(wt);
    deq_rdy  = dr;
    cycle();
  endtask

  task automatic idle(input bit dr);
    drive(0, 0, 0, 32'h0, 0, 0, dr);
  endtask

  initial begin
    rst = 1; enq_vld = 0; enq_wait = 0; enq_tag = 0; enq_data = 0;
    wake_vld = 0; wake_tag = 0; deq_rdy = 0;
    seq_ctr = 0;
    m_clear();
    @(posedge clk);
    #1;
    idle(0);
    rst = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_enq_rdy", enq_rdy, 1);
    chk("rst_deq_vld", deq_vld, 0);
    chk("rst_occ", occ, 0);
    chk("rst_full", full, 0);

    // Fill with A0..A3, then a dropped fifth enqueue
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 32'hA0 + i, 0, 0, 0);
    #1;
    chk("fill_full", full, 1);
    chk("fill_enq_rdy", enq_rdy, 0);
    chk("fill_occ", occ, 4);
    chk("fill_deq_vld", deq_vld, 1);
    chk("fill_deq_idx", deq_idx, 0);
    drive(1, 0, 0, 32'hA4, 0, 0, 0);
    #1;
    chk("drop_occ", occ, 4);
    chk("drop_head", deq_data, 32'hA0);

    // Enqueue with dequeue while full: the freed slot is not usable this cycle
    enq_vld = 1; enq_data = 32'hB0; enq_wait = 0; deq_rdy = 1;
    #1;
    chk("fullsim_enq_rdy", enq_rdy, 0);
    chk("fullsim_occ", occ, 4);
    cycle();
    #1;
    chk("after_fullsim_occ", occ, 3);
    drive(1, 0, 0, 32'hB0, 0, 0, 0);
    #1;
    chk("reuse_occ", occ, 4);
    deq_log.delete();
    for (int i = 0; i < 5; i++) idle(1);
    chk("drain_cnt", deq_log.size(), 4);
    if (deq_log.size() == 4) begin
      chk("drain0", deq_log[0], 32'hA1);
      chk("drain1", deq_log[1], 32'hA2);
      chk("drain2", deq_log[2], 32'hA3);
      chk("drain3", deq_log[3], 32'hB0);
    end

    // Wakeup ordering
    deq_log.delete();
    drive(1, 1, 3, 32'hC0, 0, 0, 1);
    drive(1, 0, 0, 32'hC1, 0, 0, 1);
    idle(1);
    drive(0, 0, 0, 32'h0, 1, 3, 1);
    #1;
    chk("wake_vld", deq_vld, 1);
    chk("wake_data", deq_data, 32'hC0);
    idle(1);
    drive(1, 1, 5, 32'hC2, 1, 5, 0);
    #1;
    chk("bypass_vld", deq_vld, 1);
    chk("bypass_data", deq_data, 32'hC2);
    idle(1);
    chk("wake_cnt", deq_log.size(), 3);
    if (deq_log.size() == 3) begin
      chk("wake_ord0", deq_log[0], 32'hC1);
      chk("wake_ord1", deq_log[1], 32'hC0);
      chk("wake_ord2", deq_log[2], 32'hC2);
    end

    // Lock stability: older entry wakes while younger one is stalled
    drive(1, 1, 7, 32'hD0, 0, 0, 0);
    drive(1, 0, 0, 32'hD1, 0, 0, 0);
    idle(0);
    drive(0, 0, 0, 32'h0, 1, 7, 0);
    #1;
    chk("lock_idx0", deq_idx, 1);
    chk("lock_data0", deq_data, 32'hD1);
    idle(0);
    #1;
    chk("lock_idx1", deq_idx, 1);
    idle(1);
    #1;
    chk("unlock_idx", deq_idx, 0);
    chk("unlock_data", deq_data, 32'hD0);
    idle(1);

    // Mid-operation reset with an active lock
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'hE0 + i, 0, 0, 0);
    idle(0);
    rst = 1;
    idle(0);
    rst = 0;
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_deq_vld", deq_vld, 0);
    chk("mrst_enq_rdy", enq_rdy, 1);
    drive(1, 0, 0, 32'hF0, 0, 0, 0);
    #1;
    chk("mrst_slot", deq_idx, 0);
    chk("mrst_data", deq_data, 32'hF0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 2) != 0);
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
